// File: rtl/gnr_floyd_ctrl.sv
// rtl/gnr_floyd_ctrl.sv - Floyd cycle-detection sweep sequencer for the GRN node array
// Optional attractor snapshot register: GNR_ATTR_STATE_EN
module gnr_floyd_ctrl #(
    parameter int NUM_NODES = 4,
    parameter int CNT_W     = 16,
    parameter int MAX_STEPS = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 reset_nos,
    output logic [NUM_NODES-1:0] init_vec,
    output logic                 start_s0,
    output logic                 start_s1,
    input  logic [NUM_NODES-1:0] s0_vec,
    input  logic [NUM_NODES-1:0] s1_vec,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [NUM_NODES-1:0] res_init,
    output logic [CNT_W-1:0]     res_steps,
    output logic [CNT_W-1:0]     res_period,
    output logic                 res_timeout,
    output logic [NUM_NODES-1:0] res_state,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_PERIOD,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0]     MAX_CNT   = CNT_W'(MAX_STEPS);
    localparam logic [NUM_NODES-1:0] LAST_INIT = '1;

    state_t                 state_q, state_d;
    logic [NUM_NODES-1:0]   cur_init_q, cur_init_d;
    logic [CNT_W-1:0]       steps_q, steps_d;
    logic [CNT_W-1:0]       per_q, per_d;
    logic                   timeout_q, timeout_d;
    logic [NUM_NODES-1:0]   attr_out;
    logic                   match;
    logic                   run_hit;

    assign match    = (s0_vec == s1_vec);
    // Right after LOAD tortoise and hare are trivially equal, so step 0 never counts as a meeting.
    assign run_hit  = (steps_q != '0) && match;
    assign init_vec = cur_init_q;
    assign busy     = (state_q != S_IDLE);

    always_comb begin
        state_d     = state_q;
        cur_init_d  = cur_init_q;
        steps_d     = steps_q;
        per_d       = per_q;
        timeout_d   = timeout_q;
        reset_nos   = 1'b0;
        start_s0    = 1'b0;
        start_s1    = 1'b0;
        res_valid   = 1'b0;
        res_init    = '0;
        res_steps   = '0;
        res_period  = '0;
        res_timeout = 1'b0;
        res_state   = '0;
        done        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_LOAD;
                    cur_init_d = '0;
                    timeout_d  = 1'b0;
                end
            end
            S_LOAD: begin
                reset_nos = 1'b1;
                steps_d   = '0;
                per_d     = '0;
                timeout_d = 1'b0;
                state_d   = S_RUN;
            end
            S_RUN: begin
                if (run_hit) begin
                    state_d = S_PERIOD;
                end else if (steps_q == MAX_CNT) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    start_s0 = 1'b1;
                    start_s1 = 1'b1;
                    steps_d  = steps_q + CNT_W'(1);
                end
            end
            S_PERIOD: begin
                // Tortoise stays frozen on an attractor state; only the hare walks the loop.
                if ((per_q != '0) && match) begin
                    state_d = S_DONE;
                end else if (per_q == MAX_CNT) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    start_s1 = 1'b1;
                    per_d    = per_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                res_valid   = 1'b1;
                res_init    = cur_init_q;
                res_steps   = steps_q;
                res_period  = per_q;
                res_timeout = timeout_q;
                res_state   = attr_out;
                if (res_ready) begin
                    if (cur_init_q == LAST_INIT) begin
                        done    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        cur_init_d = cur_init_q + NUM_NODES'(1);
                        timeout_d  = 1'b0;
                        state_d    = S_LOAD;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cur_init_q <= '0;
            steps_q    <= '0;
            per_q      <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_init_q <= cur_init_d;
            steps_q    <= steps_d;
            per_q      <= per_d;
            timeout_q  <= timeout_d;
        end
    end

`ifdef GNR_ATTR_STATE_EN
    logic [NUM_NODES-1:0] attr_state_q, attr_state_d;

    // Cleared on every LOAD so a RUN timeout reports a zero snapshot.
    always_comb begin
        attr_state_d = attr_state_q;
        if (state_q == S_LOAD) begin
            attr_state_d = '0;
        end else if ((state_q == S_RUN) && run_hit) begin
            attr_state_d = s0_vec;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            attr_state_q <= '0;
        end else begin
            attr_state_q <= attr_state_d;
        end
    end

    assign attr_out = attr_state_q;
`else
    assign attr_out = '0;
`endif

endmodule

// File: tb/tb_gnr_floyd_ctrl.sv
// tb/tb_gnr_floyd_ctrl.sv - self-checking bench for gnr_floyd_ctrl with a behavioural node array
module tb_gnr_floyd_ctrl;

    localparam int N  = 2;
    localparam int CW = 16;
    localparam int MS = 8;
`ifdef GNR_ATTR_STATE_EN
    localparam bit ATTR_EN = 1'b1;
`else
    localparam bit ATTR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          reset_nos;
    logic [N-1:0]  init_vec;
    logic          start_s0;
    logic          start_s1;
    logic [N-1:0]  s0_vec;
    logic [N-1:0]  s1_vec;
    logic          res_valid;
    logic          res_ready = 1'b1;
    logic [N-1:0]  res_init;
    logic [CW-1:0] res_steps;
    logic [CW-1:0] res_period;
    logic          res_timeout;
    logic [N-1:0]  res_state;
    logic          busy;
    logic          done;

    gnr_floyd_ctrl #(.NUM_NODES(N), .CNT_W(CW), .MAX_STEPS(MS)) dut (
        .clk(clk), .rst(rst), .start(start),
        .reset_nos(reset_nos), .init_vec(init_vec),
        .start_s0(start_s0), .start_s1(start_s1),
        .s0_vec(s0_vec), .s1_vec(s1_vec),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_init(res_init), .res_steps(res_steps), .res_period(res_period),
        .res_timeout(res_timeout), .res_state(res_state),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Node array model: mode 0 fixed point, 1 toggle, 2 hare view inverted so nothing ever matches.
    int           mode = 0;
    logic [N-1:0] s0 = '0;
    logic [N-1:0] s1 = '0;
    logic         pass = 1'b1;

    function automatic logic [N-1:0] nxt(input logic [N-1:0] x);
        return (mode == 1) ? ~x : x;
    endfunction

    always @(posedge clk) begin
        if (reset_nos) begin
            s0   <= init_vec;
            s1   <= init_vec;
            pass <= 1'b1;
        end else begin
            if (start_s0) begin
                if (pass) s0 <= nxt(s0);
                pass <= ~pass;
            end
            if (start_s1) s1 <= nxt(s1);
        end
    end

    assign s0_vec = s0;
    assign s1_vec = (mode == 2) ? ~s1 : s1;

    typedef struct {
        int init; int steps; int per; int to; int st; int rn; int s0c; int s1c;
    } rec_t;

    rec_t q[$];
    rec_t r;
    int   rn_cnt = 0, s0_cnt = 0, s1_cnt = 0, done_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            rn_cnt = 0; s0_cnt = 0; s1_cnt = 0;
        end else begin
            if (reset_nos) rn_cnt++;
            if (start_s0)  s0_cnt++;
            if (start_s1)  s1_cnt++;
            if (done)      done_cnt++;
            if (res_valid && res_ready) begin
                r.init = int'(res_init);  r.steps = int'(res_steps);
                r.per  = int'(res_period); r.to   = int'(res_timeout);
                r.st   = int'(res_state);  r.rn   = rn_cnt;
                r.s0c  = s0_cnt;           r.s1c  = s1_cnt;
                q.push_back(r);
                rn_cnt = 0; s0_cnt = 0; s1_cnt = 0;
            end
        end
    end

    rec_t tbl[12];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0d, expected %0d", nm, idx, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic run_sweep(input int m, input bit hold, input bit poke, input int base);
        int  d0;
        bit  seen;
        mode = m;
        q.delete();
        d0 = done_cnt;
        res_ready = !hold;
        pulse_start();
        if (poke) begin
            seen = 0;
            for (int c = 0; c < 50 && !seen; c++) begin
                @(negedge clk);
                if (start_s1) seen = 1;
            end
            chk("poke_run_seen", base, int'(seen), 1);
            pulse_start();
        end
        if (hold) begin
            seen = 0;
            for (int c = 0; c < 50 && !seen; c++) begin
                @(negedge clk);
                if (res_valid) seen = 1;
            end
            chk("hold_valid_seen", base, int'(seen), 1);
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                chk("hold_valid", c, int'(res_valid), 1);
                chk("hold_init", c, int'(res_init), 0);
                chk("hold_steps", c, int'(res_steps), 1);
                chk("hold_period", c, int'(res_period), 1);
                chk("hold_pulses", c, int'({reset_nos, start_s0, start_s1}), 0);
                chk("hold_init_vec", c, int'(init_vec), 0);
            end
            @(posedge clk); #1 res_ready = 1'b1;
            @(negedge clk);
            @(negedge clk);
            chk("adv_reset_nos", base, int'(reset_nos), 1);
            chk("adv_init_vec", base, int'(init_vec), 1);
        end
        seen = 0;
        for (int c = 0; c < 2000 && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk("done_seen", base, int'(seen), 1);
        @(negedge clk);
        chk("busy_after_done", base, int'(busy), 0);
        chk("done_pulses", base, done_cnt - d0, 1);
        chk("num_results", base, q.size(), 4);
        for (int k = 0; k < 4 && k < q.size(); k++) begin
            chk("res_init",    base + k, q[k].init,  tbl[base + k].init);
            chk("res_steps",   base + k, q[k].steps, tbl[base + k].steps);
            chk("res_period",  base + k, q[k].per,   tbl[base + k].per);
            chk("res_timeout", base + k, q[k].to,    tbl[base + k].to);
            chk("res_state",   base + k, q[k].st,    tbl[base + k].st);
            chk("reset_nos_n", base + k, q[k].rn,    tbl[base + k].rn);
            chk("start_s0_n",  base + k, q[k].s0c,   tbl[base + k].s0c);
            chk("start_s1_n",  base + k, q[k].s1c,   tbl[base + k].s1c);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            tbl[i]     = '{init: i, steps: 1, per: 1, to: 0, st: ATTR_EN ? i : 0,
                           rn: 1, s0c: 1, s1c: 2};
            tbl[4 + i] = '{init: i, steps: 1, per: 2, to: 0, st: ATTR_EN ? 3 - i : 0,
                           rn: 1, s0c: 1, s1c: 3};
            tbl[8 + i] = '{init: i, steps: MS, per: 0, to: 1, st: 0,
                           rn: 1, s0c: MS, s1c: MS};
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 0, int'(busy), 0);
        chk("rst_valid", 0, int'(res_valid), 0);
        chk("rst_ctrl", 0, int'({reset_nos, start_s0, start_s1, done}), 0);
        chk("rst_init_vec", 0, int'(init_vec), 0);
        chk("rst_res", 0, int'({res_init, res_steps, res_period, res_timeout, res_state}), 0);
        @(posedge clk); #1 rst = 1'b0;

        run_sweep(0, 1'b1, 1'b0, 0);
        run_sweep(1, 1'b0, 1'b1, 4);
        run_sweep(2, 1'b0, 1'b0, 8);

        // Abort a long RUN, then a fresh sweep must begin again at init 0.
        mode = 2;
        pulse_start();
        repeat (4) @(negedge clk);
        chk("mid_run_active", 0, int'(start_s1), 1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", 0, int'(busy), 0);
        chk("abort_ctrl", 0, int'({reset_nos, start_s0, start_s1, res_valid, done}), 0);
        chk("abort_init_vec", 0, int'(init_vec), 0);
        run_sweep(0, 1'b0, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gnr_floyd_ctrl.md
Name: gnr_floyd_ctrl

Overview:
- Sequencer that sits directly upstream of the GRN node array and drives every node's `reset_nos`, `init_state`, `start_s0` and `start_s1`.
- Consumes the nodes' tortoise (`s0`) and hare (`s1`) state bits, packed as vectors.
- Sweeps all initial states and runs Floyd cycle detection on each: the tortoise steps every other cycle via each node's pass bit, the hare steps every cycle.
- Reports one result per initial state over a valid/ready interface: initial state, transient step count, attractor period and timeout flag.

Parameters:
- NUM_NODES, 4, number of network nodes (width of all state vectors)
- CNT_W, 16, width of the step and period counters
- MAX_STEPS, 1000, timeout limit for both the RUN phase and the PERIOD phase (must be < 2^CNT_W)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins a sweep (honoured in IDLE only)
- reset_nos  out  1  load pulse to all nodes
- init_vec  out  NUM_NODES  per-node init_state; bit i goes to node i
- start_s0  out  1  tortoise step enable, broadcast to all nodes
- start_s1  out  1  hare step enable, broadcast to all nodes
- s0_vec  in  NUM_NODES  packed node s0 outputs
- s1_vec  in  NUM_NODES  packed node s1 outputs
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts the result
- res_init  out  NUM_NODES  initial state of this result
- res_steps  out  CNT_W  RUN steps until tortoise and hare met
- res_period  out  CNT_W  attractor period
- res_timeout  out  1  the limit was hit in either phase
- res_state  out  NUM_NODES  attractor state snapshot (see Optional Feature)
- busy  out  1  high whenever the FSM is not IDLE
- done  out  1  one-cycle pulse after the last result is accepted

Behaviour:
- Reset (rst=1): state=IDLE, cur_init=0, all counters 0, all outputs 0.
- rst has priority over everything and aborts any phase immediately; the nodes receive no reset_nos until the next LOAD.
- FSM states: IDLE, LOAD, RUN, PERIOD, DONE.
- match = (s0_vec == s1_vec), computed combinationally.
- start_s0, start_s1 and reset_nos are combinational decodes of the registered state, counters and match. init_vec = cur_init at all times.
- IDLE:
  - start=1 -> LOAD with cur_init=0.
  - start is ignored in every other state.
- LOAD (1 cycle):
  - reset_nos=1.
  - steps<=0, per<=0.
  - -> RUN.
- RUN, evaluated in priority order:
  - if steps!=0 and match: no start; -> PERIOD.
  - else if steps==MAX_STEPS: no start; timeout<=1; -> DONE.
  - else: start_s0=start_s1=1 and steps<=steps+1.
  - The steps==0 guard exists because the tortoise and hare are equal right after load.
- PERIOD: start_s0 is held 0, which freezes the tortoise.
  - if per!=0 and match: -> DONE.
  - else if per==MAX_STEPS: timeout<=1; -> DONE.
  - else: start_s1=1 and per<=per+1.
- DONE:
  - res_valid=1.
  - res_init, res_steps, res_period, res_timeout and res_state are held stable while res_ready=0.
  - On res_valid & res_ready:
    - if cur_init == 2^NUM_NODES-1: done=1 that same cycle, -> IDLE.
    - else: cur_init<=cur_init+1, timeout<=0, -> LOAD.
- On a RUN timeout, res_period=0.
- busy=1 in LOAD, RUN, PERIOD and DONE.
- No control outputs are asserted in IDLE or DONE.
- Counters never wrap, because they are capped by MAX_STEPS.

Optional Feature:
- Macro: GNR_ATTR_STATE_EN.
- Defined: on the RUN->PERIOD transition, s0_vec is registered into attr_state; res_state = attr_state in DONE. On a RUN timeout, res_state=0.
- Undefined: no snapshot register is built and res_state is tied to 0.

Test Plan:
- Fixed-point network (nodes hold state), NUM_NODES=2, one start pulse, res_ready=1 -> 4 results with init 0..3, each res_steps=1, res_period=1, res_timeout=0; done pulses once; busy falls the next cycle.
- Toggle network (each step inverts every bit) -> every result res_steps=1, res_period=2; reset_nos high exactly 1 cycle per init; start_s0=0 throughout PERIOD.
- Bench model whose s0_vec and s1_vec never match, MAX_STEPS=8 -> res_timeout=1, res_steps=8, res_period=0, exactly 8 start_s1 pulses in RUN.
- res_ready held 0 for 5 cycles in DONE -> res_* stable, no reset_nos or start pulses, cur_init unchanged; advances the cycle after res_ready=1.
- rst asserted mid-RUN -> next cycle busy=0, all outputs 0; a later start restarts from init 0.
- start pulsed during RUN -> ignored, sweep continues; with GNR_ATTR_STATE_EN on a fixed-point network, res_state equals res_init.
